// File: rtl/handshake_pkg.sv
// Shared types and constants for the four-phase chunked link receiver.
package handshake_pkg;

    localparam int unsigned CHUNK_W = 6;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } state_e;

    function automatic int unsigned num_chunks(input int unsigned n);
        return (n + CHUNK_W - 1) / CHUNK_W;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic single-bit multi-flop synchronizer with asynchronous active-high reset to 0.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/handshake_receiver.sv
// Four-phase req/ack receiver: reassembles LSB-first 6-bit chunks into N-bit words and
// pulses reg_valid for one cycle on every completed word.
module handshake_receiver
    import handshake_pkg::*;
#(
    parameter int unsigned N           = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk_receiver,
    input  logic               rst,
    input  logic               wire_req,
    input  logic [CHUNK_W-1:0] wire_data_in,
    input  logic               wire_read_en,
    output logic               reg_ack,
    output logic [N-1:0]       reg_data_out,
    output logic               reg_valid,
    output logic               reg_busy
);

    localparam int unsigned NumChunks = num_chunks(N);
    localparam int unsigned CntW      = ($clog2(NumChunks + 1) < 1) ? 1 : $clog2(NumChunks + 1);
    localparam int unsigned IdxW      = ($clog2(N) < 1) ? 1 : $clog2(N);
    localparam logic [CntW-1:0] LastIdx = CntW'(NumChunks - 1);

    logic            req_s;
    state_e          state_q;
    logic            ack_q;
    logic            valid_q;
    logic [N-1:0]    data_q;
    logic [N-1:0]    asm_q;
    logic [N-1:0]    asm_d;
    logic [CntW-1:0] cnt_q;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk_i (clk_receiver),
        .rst_i (rst),
        .d_i   (wire_req),
        .q_o   (req_s)
    );

    // Overlay the incoming chunk at its slot; bits that land at or above N are dropped.
    always_comb begin
        int unsigned pos;
        asm_d = asm_q;
        pos   = 0;
        for (int unsigned i = 0; i < CHUNK_W; i++) begin
            pos = CHUNK_W * 32'(cnt_q) + i;
            if (pos < N) begin
                asm_d[pos[IdxW-1:0]] = wire_data_in[i];
            end
        end
    end

    always_ff @(posedge clk_receiver or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            asm_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!wire_read_en) begin
                        cnt_q <= '0;
                        asm_q <= '0;
                    end else if (req_s) begin
                        ack_q   <= 1'b1;
                        state_q <= WAIT_LOW;
                        if (cnt_q == LastIdx) begin
                            data_q  <= asm_d;
                            valid_q <= 1'b1;
                            cnt_q   <= '0;
                            asm_q   <= '0;
                        end else begin
                            asm_q <= asm_d;
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                // A started handshake always completes, regardless of wire_read_en.
                WAIT_LOW: begin
                    if (!req_s) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign reg_ack      = ack_q;
    assign reg_valid    = valid_q;
    assign reg_data_out = data_q;
    assign reg_busy     = (cnt_q != '0);

endmodule

// File: tb/tb_handshake_receiver.sv
// Bench for handshake_receiver: N=16 and N=6 instances share one four-phase transmitter.
module tb_handshake_receiver;

    logic clk_receiver = 1'b0;
    always #5 clk_receiver = ~clk_receiver;

    logic        rst;
    logic        wire_req;
    logic        wire_read_en;
    logic [5:0]  wire_data_in;

    logic        ack16, valid16, busy16;
    logic [15:0] data16;
    logic        ack6, valid6, busy6;
    logic [5:0]  data6;

    handshake_receiver #(
        .N           (16),
        .SYNC_STAGES (2)
    ) dut16 (
        .clk_receiver (clk_receiver),
        .rst          (rst),
        .wire_req     (wire_req),
        .wire_data_in (wire_data_in),
        .wire_read_en (wire_read_en),
        .reg_ack      (ack16),
        .reg_data_out (data16),
        .reg_valid    (valid16),
        .reg_busy     (busy16)
    );

    handshake_receiver #(
        .N           (6),
        .SYNC_STAGES (2)
    ) dut6 (
        .clk_receiver (clk_receiver),
        .rst          (rst),
        .wire_req     (wire_req),
        .wire_data_in (wire_data_in),
        .wire_read_en (wire_read_en),
        .reg_ack      (ack6),
        .reg_data_out (data6),
        .reg_valid    (valid6),
        .reg_busy     (busy6)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: chunks accepted since the last flush, summed by position.
    int          cnt16 = 0;
    logic [15:0] asm16 = '0;
    logic [15:0] last16 = '0;
    logic [5:0]  last6 = '0;
    logic [15:0] exp16_q[$];
    logic [5:0]  exp6_q[$];

    typedef struct {
        logic [5:0]  chunk;
        logic        drop_mid;
        int          idle_off;
        logic [15:0] exp_data;
        logic        exp_busy_cap;
        logic        exp_busy_end;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [5:0] chunk);
        logic [31:0] wide;
        wide  = {26'b0, chunk} << (6 * cnt16);
        asm16 = asm16 | wide[15:0];
        cnt16++;
        if (cnt16 == 3) begin
            exp16_q.push_back(asm16);
            last16 = asm16;
            cnt16  = 0;
            asm16  = '0;
        end
        exp6_q.push_back(chunk);
        last6 = chunk;
    endtask

    task automatic model_flush();
        cnt16 = 0;
        asm16 = '0;
    endtask

    task automatic raise_req(input logic [5:0] chunk);
        int n;
        check("ack_low_before_req", ack16, 0);
        wire_data_in = chunk;
        wire_req     = 1'b1;
        n = 0;
        do begin
            @(posedge clk_receiver);
            #1;
            n++;
        end while (!ack16 && n < 20);
        check("ack_rise_latency", n, 3);
        check("ack6_rise", ack6, 1);
        if (ack16) begin
            model_accept(chunk);
            check("data16_at_cap", data16, last16);
            check("data6_at_cap", data6, last6);
            check("busy16_at_cap", busy16, cnt16 != 0);
            check("busy6_at_cap", busy6, 0);
        end
    endtask

    task automatic lower_req(input logic drop_mid);
        int n;
        if (drop_mid) wire_read_en = 1'b0;
        wire_req = 1'b0;
        n = 0;
        do begin
            @(posedge clk_receiver);
            #1;
            n++;
        end while (ack16 && n < 20);
        check("ack_fall_latency", n, 3);
        check("ack6_fall", ack6, 0);
    endtask

    task automatic idle(input int n, input logic ren);
        wire_read_en = ren;
        repeat (n) @(posedge clk_receiver);
        #1;
        if (!ren && n > 0) model_flush();
    endtask

    task automatic send(input logic [5:0] chunk, input logic drop_mid);
        wire_read_en = 1'b1;
        raise_req(chunk);
        lower_req(drop_mid);
    endtask

    // Every valid pulse must deliver the next word the model completed.
    always @(negedge clk_receiver) begin
        if (!rst) begin
            if (valid16) begin
                if (exp16_q.size() == 0) check("valid16_unexpected", 1, 0);
                else check("valid16_word", data16, exp16_q.pop_front());
            end
            if (valid6) begin
                if (exp6_q.size() == 0) check("valid6_unexpected", 1, 0);
                else check("valid6_word", data6, exp6_q.pop_front());
            end
        end
    end

    initial begin
        logic [5:0] c;
        logic       dm;
        int         r;

        vecs[0]  = '{6'h2F, 1'b0, 0, 16'h0000, 1'b1, 1'b1};
        vecs[1]  = '{6'h3B, 1'b0, 0, 16'h0000, 1'b1, 1'b1};
        vecs[2]  = '{6'h0B, 1'b0, 0, 16'hBEEF, 1'b0, 1'b0};
        vecs[3]  = '{6'h2F, 1'b0, 5, 16'hBEEF, 1'b1, 1'b0};
        vecs[4]  = '{6'h01, 1'b0, 0, 16'hBEEF, 1'b1, 1'b1};
        vecs[5]  = '{6'h00, 1'b0, 0, 16'hBEEF, 1'b1, 1'b1};
        vecs[6]  = '{6'h00, 1'b0, 0, 16'h0001, 1'b0, 1'b0};
        vecs[7]  = '{6'h05, 1'b1, 1, 16'h0001, 1'b1, 1'b0};
        vecs[8]  = '{6'h00, 1'b0, 0, 16'h0001, 1'b1, 1'b1};
        vecs[9]  = '{6'h3F, 1'b0, 0, 16'h0001, 1'b1, 1'b1};
        vecs[10] = '{6'h00, 1'b0, 0, 16'h0FC0, 1'b0, 1'b0};
        vecs[11] = '{6'h01, 1'b0, 0, 16'h0FC0, 1'b1, 1'b1};
        vecs[12] = '{6'h00, 1'b0, 0, 16'h0FC0, 1'b1, 1'b1};
        vecs[13] = '{6'h3F, 1'b0, 0, 16'hF001, 1'b0, 1'b0};
        vecs[14] = '{6'h15, 1'b0, 0, 16'hF001, 1'b1, 1'b1};
        vecs[15] = '{6'h2A, 1'b0, 1, 16'hF001, 1'b1, 1'b0};

        rst          = 1'b1;
        wire_req     = 1'b0;
        wire_read_en = 1'b1;
        wire_data_in = '0;
        repeat (3) @(posedge clk_receiver);
        #1;
        check("rst_ack16", ack16, 0);
        check("rst_data16", data16, 0);
        check("rst_valid16", valid16, 0);
        check("rst_busy16", busy16, 0);
        check("rst_ack6", ack6, 0);
        check("rst_data6", data6, 0);
        @(negedge clk_receiver);
        rst = 1'b0;
        idle(2, 1'b1);

        for (int i = 0; i < 16; i++) begin
            wire_read_en = 1'b1;
            raise_req(vecs[i].chunk);
            check("tbl_data16", data16, vecs[i].exp_data);
            check("tbl_busy_cap", busy16, vecs[i].exp_busy_cap);
            check("tbl_data6", data6, vecs[i].chunk);
            lower_req(vecs[i].drop_mid);
            if (vecs[i].idle_off > 0) idle(vecs[i].idle_off, 1'b0);
            else idle(1, 1'b1);
            check("tbl_busy_end", busy16, vecs[i].exp_busy_end);
        end

        // Reset while a handshake is in progress with a partial word held.
        send(6'h2F, 1'b0);
        idle(1, 1'b1);
        check("pre_rst_busy", busy16, 1);
        raise_req(6'h11);
        @(negedge clk_receiver);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ack16", ack16, 0);
        check("midrst_ack6", ack6, 0);
        check("midrst_data16", data16, 0);
        check("midrst_data6", data6, 0);
        check("midrst_busy16", busy16, 0);
        check("midrst_valid6", valid6, 0);
        model_flush();
        last16   = '0;
        last6    = '0;
        wire_req = 1'b0;
        repeat (2) @(posedge clk_receiver);
        @(negedge clk_receiver);
        rst = 1'b0;
        idle(3, 1'b1);
        send(6'h34, 1'b0);
        send(6'h08, 1'b0);
        send(6'h01, 1'b0);
        check("post_rst_word", data16, 16'h1234);
        idle(1, 1'b1);

        for (int i = 0; i < 60; i++) begin
            c  = 6'($urandom_range(0, 63));
            dm = ($urandom_range(0, 7) == 0);
            send(c, dm);
            r = $urandom_range(0, 5);
            if (dm || r == 0) idle($urandom_range(1, 4), 1'b0);
            else idle($urandom_range(0, 2), 1'b1);
            check("rnd_busy16", busy16, cnt16 != 0);
            check("rnd_data16_hold", data16, last16);
        end

        idle(5, 1'b1);
        check("q16_drained", exp16_q.size(), 0);
        check("q6_drained", exp6_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
